// File: rtl/arb_pkg.sv
// Shared constants and helpers for the arbitrating multiplexer.
package arb_pkg;

  localparam int unsigned MODE_RR    = 0;
  localparam int unsigned MODE_FIXED = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Select width is never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_if.sv
// Handshake bundle between N producers, the arbitrating mux and one consumer.
interface arb_mux_if
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 2
);
  localparam int unsigned SELW = sel_width(N);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/arb_grant.sv
// Combinational grant: rotate requests by the pointer, pick the lowest set bit, rotate back.
module arb_grant
  import arb_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            mode,
  output logic [N-1:0]    gnt_onehot,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  localparam logic [SELW:0] NumCh = (SELW + 1)'(N);

  logic [SELW-1:0] eff_ptr;
  logic [2*N-1:0]  dbl;
  logic [N-1:0]    rot;
  logic [SELW-1:0] off;
  logic [SELW:0]   sum;

  always_comb begin
    eff_ptr = mode ? '0 : ptr;
    dbl     = {req, req} >> eff_ptr;
    rot     = dbl[N-1:0];
    any     = |req;
    off     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = SELW'(i);
    end
    // Explicit wrap so non-power-of-2 channel counts never yield an out-of-range index.
    sum = {1'b0, eff_ptr} + {1'b0, off};
    if (sum >= NumCh) sum = sum - NumCh;
    gnt_idx    = sum[SELW-1:0];
    gnt_onehot = any ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrating mux with a single registered output stage and valid/ready handshakes.
module arb_mux
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 2,
  parameter int unsigned MODE  = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  arb_mux_if.slave bus
);

  localparam int unsigned SELW = sel_width(N);
  localparam logic ModeFixed = (MODE == MODE_FIXED);

  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;

  logic [N-1:0]    gnt_onehot;
  logic [SELW-1:0] gnt_idx;
  logic            any;
  logic            load;

  arb_grant #(
    .N (N)
  ) u_grant (
    .req        (bus.in_valid),
    .ptr        (ptr_q),
    .mode       (ModeFixed),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  assign load = !out_valid_q || bus.out_ready;

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    // Nothing is accepted while reset is held, so no transfer is lost.
    bus.in_ready = (rst_n && load) ? gnt_onehot : '0;
    if (load) begin
      if (any) begin
        out_valid_d = 1'b1;
        out_data_d  = bus.in_data[gnt_idx*WIDTH +: WIDTH];
        out_sel_d   = gnt_idx;
        if (!ModeFixed) begin
          ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule
